rollover_counter: RTL and testbench



---
 rtl/rollover_counter.sv | 112 +++++++++++
 tb/tb_rollover_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rollover_counter.sv
// Programmable modulo-N prescaler producing a one-cycle roll-over strobe.
// Optional one-shot mode (DONE state, i_oneshot port) is built when ROLLOVER_ONESHOT_EN is defined.
module rollover_counter #(
    parameter int WIDTH        = 8,
    parameter int RESET_PERIOD = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_period,
    input  logic             i_period_load,
`ifdef ROLLOVER_ONESHOT_EN
    input  logic             i_oneshot,
`endif
    output logic [WIDTH-1:0] o_count,
    output logic             o_roll_over,
    output logic             o_period_ack,
    output logic             o_period_err
);

    localparam logic [WIDTH-1:0] RST_PER = WIDTH'(RESET_PERIOD);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        STOPPED,
        RUNNING,
        PENDING
`ifdef ROLLOVER_ONESHOT_EN
        , DONE
`endif
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q, period_q, shadow_q;
    logic             staged_q, roll_q, ack_q, err_q;

    logic load_ok_d, load_bad_d, at_term_d, idle_d;

    assign load_ok_d  = i_period_load && (i_period != '0);
    assign load_bad_d = i_period_load && (i_period == '0);
    // A period applied while stopped may sit below the held count; >= lets the
    // next enabled edge wrap instead of running on to 2^WIDTH.
    assign at_term_d  = (count_q >= (period_q - ONE));
`ifdef ROLLOVER_ONESHOT_EN
    assign idle_d     = !i_enable || (state_q == DONE);
`else
    assign idle_d     = !i_enable;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= STOPPED;
            count_q  <= '0;
            period_q <= RST_PER;
            shadow_q <= '0;
            staged_q <= 1'b0;
            roll_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            roll_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= load_bad_d;
            if (idle_d) begin
                // Counter is not advancing, so a new period can take effect at once.
                if (load_ok_d) begin
                    period_q <= i_period;
                    ack_q    <= 1'b1;
                end else if (staged_q) begin
                    period_q <= shadow_q;
                    ack_q    <= 1'b1;
                end
                staged_q <= 1'b0;
                if (!i_enable)
                    state_q <= STOPPED;
            end else begin
                if (at_term_d) begin
                    count_q <= '0;
                    roll_q  <= 1'b1;
                    if (staged_q) begin
                        period_q <= shadow_q;
                        ack_q    <= 1'b1;
                    end
                end else begin
                    count_q <= count_q + ONE;
                end

                // A load on the wrap edge stages for the following wrap.
                if (load_ok_d) begin
                    shadow_q <= i_period;
                    staged_q <= 1'b1;
                    state_q  <= PENDING;
                end else if (at_term_d) begin
                    staged_q <= 1'b0;
                    state_q  <= RUNNING;
                end else begin
                    state_q  <= staged_q ? PENDING : RUNNING;
                end
`ifdef ROLLOVER_ONESHOT_EN
                if (at_term_d && i_oneshot)
                    state_q <= DONE;
`endif
            end
        end
    end

    assign o_count      = count_q;
    assign o_roll_over  = roll_q;
    assign o_period_ack = ack_q;
    assign o_period_err = err_q;

endmodule

// File: tb/tb_rollover_counter.sv
// Randomized + directed bench for rollover_counter against a behavioural model.
module tb_rollover_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_enable;
    logic [7:0] i_period;
    logic       i_period_load;
    logic       os_in;
`ifdef ROLLOVER_ONESHOT_EN
    logic       i_oneshot;
    assign i_oneshot = os_in;
`endif
    logic [7:0] o_count;
    logic       o_roll_over, o_period_ack, o_period_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rollover_counter #(.WIDTH(8), .RESET_PERIOD(10)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_enable     (i_enable),
        .i_period     (i_period),
        .i_period_load(i_period_load),
`ifdef ROLLOVER_ONESHOT_EN
        .i_oneshot    (i_oneshot),
`endif
        .o_count      (o_count),
        .o_roll_over  (o_roll_over),
        .o_period_ack (o_period_ack),
        .o_period_err (o_period_err)
    );

    // Behavioural model: active period, staged period, count, strobes.
    typedef struct {
        int cnt, per, shadow;
        bit staged, done, roll, ack, err;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.cnt = 0; r.per = 10; r.shadow = 0;
        r.staged = 0; r.done = 0; r.roll = 0; r.ack = 0; r.err = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t s, bit en, bit ld, int p, bit os);
        model_t n;
        bit ok;
        n = s;
        ok = ld && (p != 0);
        n.roll = 0; n.ack = 0;
        n.err = ld && (p == 0);
        if (!en || s.done) begin
            if (ok) begin n.per = p; n.ack = 1; end
            else if (s.staged) begin n.per = s.shadow; n.ack = 1; end
            n.staged = 0;
            if (!en) n.done = 0;
        end else begin
            if (s.cnt + 1 >= s.per) begin
                n.cnt = 0; n.roll = 1;
                if (s.staged) begin n.per = s.shadow; n.ack = 1; n.staged = 0; end
                if (os) n.done = 1;
            end else begin
                n.cnt = s.cnt + 1;
            end
            if (ok) begin n.shadow = p; n.staged = 1; end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= model_reset();
        else          m <= model_step(m, i_enable, i_period_load, int'(i_period), os_in);
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_count", int'(o_count), m.cnt);
        check("model_roll",  int'(o_roll_over), int'(m.roll));
        check("model_ack",   int'(o_period_ack), int'(m.ack));
        check("model_err",   int'(o_period_err), int'(m.err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int c, input int r, input int a);
        check({name, "_count"}, int'(o_count), c);
        check({name, "_roll"},  int'(o_roll_over), r);
        check({name, "_ack"},   int'(o_period_ack), a);
    endtask

    task automatic load(input int p);
        i_period_load = 1'b1;
        i_period      = p[7:0];
    endtask

    initial begin
        reset_n = 1'b0; i_enable = 1'b0; i_period = '0; i_period_load = 1'b0; os_in = 1'b0;
        tick(); tick();
        chk("reset", 0, 0, 0);
        check("reset_err", int'(o_period_err), 0);
        reset_n = 1'b1; i_enable = 1'b1;

        // Strobes at cycles 10, 20, 30 after release.
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk("free_run", k % 10, int'(k % 10 == 0), 0);
        end

        // Enable gating at count 6.
        for (int k = 1; k <= 6; k++) tick();
        chk("gate_pre", 6, 0, 0);
        i_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin tick(); chk("gate_hold", 6, 0, 0); end
        i_enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin tick(); chk("gate_resume", (6 + k) % 10, int'(k == 4), 0); end

        // Runtime load of 4 at count 2.
        tick(); tick();
        load(4);
        tick();
        i_period_load = 1'b0;
        for (int k = 4; k <= 9; k++) begin tick(); chk("ld4_wait", k, 0, 0); end
        tick(); chk("ld4_wrap", 0, 1, 1);
        for (int k = 0; k < 8; k++) begin tick(); chk("ld4_run", (k + 1) % 4, int'(k % 4 == 3), 0); end

        // Period 0 rejected.
        load(0);
        tick(); check("err_pulse", int'(o_period_err), 1);
        i_period_load = 1'b0;
        tick(); check("err_clear", int'(o_period_err), 0);
        tick(); chk("err_keep", 3, 0, 0);
        tick(); chk("err_keep_wrap", 0, 1, 0);

        // Period 1.
        load(1);
        tick(); i_period_load = 1'b0;
        tick(); tick();
        tick(); chk("p1_apply", 0, 1, 1);
        for (int k = 0; k < 5; k++) begin tick(); chk("p1_run", 0, 1, 0); end

        // Period 255, staged on a wrap edge.
        load(255);
        tick(); chk("p255_stage", 0, 1, 0);
        i_period_load = 1'b0;
        tick(); chk("p255_apply", 0, 1, 1);
        for (int k = 1; k <= 254; k++) begin tick(); check("p255_count", int'(o_count), k); end
        check("p255_noroll", int'(o_roll_over), 0);
        tick(); chk("p255_wrap", 0, 1, 0);

        // Restore 10, then load 3 exactly on the wrap edge.
        load(10);
        tick(); i_period_load = 1'b0;
        for (int k = 0; k < 253; k++) tick();
        tick(); chk("p10_apply", 0, 1, 1);
        for (int k = 0; k < 9; k++) tick();
        chk("sim_pre", 9, 0, 0);
        load(3);
        tick(); chk("sim_wrap_old", 0, 1, 0);
        i_period_load = 1'b0;
        for (int k = 1; k <= 9; k++) begin tick(); chk("sim_old_period", k, 0, 0); end
        tick(); chk("sim_apply", 0, 1, 1);
        tick(); tick(); tick(); chk("sim_p3", 0, 1, 0);

        // Async reset mid-count discards a staged period.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        load(4);
        tick(); i_period_load = 1'b0;
        tick(); check("arst_pre", int'(o_count), 5);
        reset_n = 1'b0;
        #1;
        chk("arst_now", 0, 0, 0);
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin tick(); chk("arst_after", k % 10, int'(k == 10), 0); end

        // Random phase.
        for (int k = 0; k < 3000; k++) begin
            int r;
            i_enable = ($urandom % 8) != 0;
            i_period_load = ($urandom % 10) == 0;
            r = $urandom % 8;
            if (r == 0)      i_period = 8'd0;
            else if (r == 1) i_period = 8'd1;
            else if (r == 2) i_period = ($urandom % 4 == 0) ? 8'd255 : 8'd2;
            else             i_period = 8'($urandom_range(2, 12));
            if ($urandom % 400 == 0) reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
        end
        i_period_load = 1'b0;

`ifdef ROLLOVER_ONESHOT_EN
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; i_enable = 1'b0; os_in = 1'b1;
        load(4);
        tick(); chk("os_load", 0, 0, 1);
        i_period_load = 1'b0; i_enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin tick(); chk("os_first", k % 4, int'(k == 4), 0); end
        for (int k = 0; k < 6; k++) begin tick(); chk("os_done", 0, 0, 0); end
        i_enable = 1'b0;
        tick();
        i_enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin tick(); chk("os_rearm", k % 4, int'(k == 4), 0); end
        for (int k = 0; k < 3; k++) begin tick(); chk("os_done2", 0, 0, 0); end
        os_in = 1'b0;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
